// File: rtl/tc_param_stack_if.sv
// ============================================================================
//  Module   : tc_param_stack_if
//  Brief    : Push/pop request and status bundle for the parametrised LIFO
//             stack. The master drives requests and data; the slave (the
//             stack) returns popped data and occupancy/error status.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface tc_param_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Request side
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] in;

    // Response / status side
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    // Requester view
    modport master (
        output push, pop, in,
        input  out, out_valid, count, empty, full, overflow, underflow
    );

    // Stack view
    modport slave (
        input  push, pop, in,
        output out, out_valid, count, empty, full, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/tc_param_stack.sv
// ============================================================================
//  Module   : tc_param_stack
//  Brief    : Parametrised LIFO stack with registered pop data (1-cycle
//             latency), occupancy count, full/empty decodes and sticky
//             overflow/underflow flags. Simultaneous push+pop replaces the
//             top entry, or bypasses input to output when the stack is empty.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tc_param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  wire logic             clk,
    input  wire logic             rst,
    tc_param_stack_if.slave       bus
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(DEPTH + 1);
    // DEPTH >= 2, so the address needs at least one bit and never exceeds CNT_W
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q,       ovf_d;
    logic             unf_q,       unf_d;

    // Memory write port, decoded from the request mix
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;

    // Status decodes and addresses derived from the count register
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top_addr;   // index of the current top entry (valid when !w_empty)
    logic [AW-1:0]    w_next_addr;  // index of the next free slot (valid when !w_full)
    logic [WIDTH-1:0] w_top_data;

    assign w_empty     = (cnt_q == '0);
    assign w_full      = (cnt_q == C_DEPTH);
    assign w_top_addr  = AW'(cnt_q - C_ONE);
    assign w_next_addr = cnt_q[AW-1:0];
    // Read-before-write: this sees the pre-edge contents even in the replace case
    assign w_top_data  = mem_q[w_top_addr];

    // Next-state decode for count, output register, sticky flags and memory write
    always_comb begin
        cnt_d       = cnt_q;
        out_d       = '0;
        out_valid_d = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        w_wr_en     = 1'b0;
        w_wr_addr   = w_next_addr;
        w_wr_data   = bus.in;

        unique case ({bus.push, bus.pop})
            2'b10: begin
                // Push only: append unless full, in which case the word is dropped
                if (!w_full) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_next_addr;
                    cnt_d     = cnt_q + C_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                // Pop only: present the top entry next cycle, or flag an empty pop
                if (!w_empty) begin
                    out_d       = w_top_data;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q - C_ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end
            2'b11: begin
                // Push+pop: replace the top entry (count unchanged, legal even
                // when full); on an empty stack the input is passed straight out
                if (!w_empty) begin
                    out_d       = w_top_data;
                    out_valid_d = 1'b1;
                    w_wr_en     = 1'b1;
                    w_wr_addr   = w_top_addr;
                end else begin
                    out_d       = bus.in;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                // Idle: output register clears, everything else holds
            end
        endcase
    end

    // Control/status registers; reset discards any request in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Storage array; not cleared by reset since entries above count are unobservable
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            mem_q[w_wr_addr] <= w_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = cnt_q;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

`default_nettype wire
